// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: first-word-fall-through, sticky overflow
// on dropped bytes, almost-full flag decoded from the occupancy register.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     afull,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, drop;

  always_comb begin
    pop   = valid_q & out_ready;
    full  = (count_q == FULL_CNT);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    push  = in_valid & (~full | pop);
    drop  = in_valid & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);

    // Set wins over clear when a drop coincides with ovf_clear.
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset; the output mux hides anything stale.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? mem_q[rd_ptr_q] : 8'h00;
  assign count     = count_q;
  assign afull     = (count_q >= AFULL_CNT);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run, all checked against a queue-based reference of the FIFO behaviour.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          afull;
  logic          overflow;
  logic          ovf_clear;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];
  logic       ovf_m;

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .afull(afull), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  // Called at a falling edge: drive inputs, advance the model, run one rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    bit pop_m, push_m, drop_m;
    in_valid = v; in_data = d; out_ready = r; ovf_clear = c;
    #1;
    if (out_valid && out_ready) act_q.push_back(out_data);
    pop_m  = (mq.size() > 0) && r;
    push_m = v && ((mq.size() < DEPTH) || pop_m);
    drop_m = v && (mq.size() == DEPTH) && !pop_m;
    if (pop_m)  exp_q.push_back(mq.pop_front());
    if (push_m) mq.push_back(d);
    if (drop_m)  ovf_m = 1'b1;
    else if (c)  ovf_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; ovf_clear = 1'b0;
    mq.delete(); ovf_m = 1'b0;
    #1;
    n_chk++;
    if (count !== '0 || out_valid !== 1'b0 || out_data !== 8'h00 || afull !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d valid=%b data=%h afull=%b ovf=%b, required all zero",
               count, out_valid, out_data, afull, overflow);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    clear_logs();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== CW'(1) || afull !== 1'b0) begin
      n_fail++;
      $display("FAIL single_push: valid=%b data=%h count=%0d afull=%b, required 1 a5 1 0",
               out_valid, out_data, count, afull);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (act_q.size() != 1 || act_q[0] !== 8'hA5 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: popped %0d bytes valid=%b, required one a5 then empty", act_q.size(), out_valid);
    end
  endtask

  task automatic test_fill_drain_overflow();
    clear_logs();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      n_chk++;
      if (count !== CW'(i + 1) || afull !== ((i + 1) >= AFL)) begin
        n_fail++;
        $display("FAIL fill_count: count=%0d afull=%b, required %0d %b", count, afull, i + 1, (i + 1) >= AFL);
      end
    end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    n_chk++;
    if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL full_drop: overflow=%b count=%0d, required 1 %0d", overflow, count, DEPTH);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (act_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL drain_len: got %0d bytes, required %0d", act_q.size(), DEPTH);
    end
    for (int i = 0; i < act_q.size() && i < DEPTH; i++) begin
      n_chk++;
      if (act_q[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got %h, required %h", i, act_q[i], 8'(i));
      end
    end
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== '0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL after_drain: valid=%b data=%h count=%0d ovf=%b, required 0 00 0 1",
               out_valid, out_data, count, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    clear_logs();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    n_chk++;
    if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: count=%0d overflow=%b, required %0d 0", count, overflow, DEPTH);
    end
    // Drop coinciding with ovf_clear must leave overflow set.
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: overflow=%b, required 1", overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (act_q.size() != exp_q.size() || act_q.size() == 0 || act_q[act_q.size()-1] !== 8'h77) begin
      n_fail++;
      $display("FAIL push_pop_last: got %0d bytes (last %h), required %0d ending 77",
               act_q.size(), act_q.size() ? act_q[act_q.size()-1] : 8'h00, exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL push_pop_order[%0d]: got %h, required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stream_wrap();
    int sent;
    clear_logs();
    sent = 0;
    for (int c = 0; c < 200 && (sent < 40 || mq.size() > 0); c++) begin
      logic v;
      v = (sent < 40) && (c % 2 == 0);
      cycle(v, 8'($urandom_range(0, 255)), (c % 2 == 1), 1'b0);
      if (v) sent++;
    end
    n_chk++;
    if (act_q.size() != 40 || exp_q.size() != 40 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_len: got %0d bytes ovf=%b, required 40 0", act_q.size(), overflow);
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream_order[%0d]: got %h, required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
      n_chk++;
      if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) ||
          out_data !== (mq.size() ? mq[0] : 8'h00) || afull !== (mq.size() >= AFL) ||
          overflow !== ovf_m) begin
        n_fail++;
        $display("FAIL random_cycle%0d: count=%0d valid=%b data=%h afull=%b ovf=%b, required %0d %b %h %b %b",
                 c, count, out_valid, out_data, afull, overflow, mq.size(), mq.size() != 0,
                 mq.size() ? mq[0] : 8'h00, mq.size() >= AFL, ovf_m);
      end
    end
    n_chk++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_popcount: got %0d, required %0d", act_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_chk++;
    if (count !== CW'(5) || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: count=%0d ovf=%b, required 5 1", count, overflow);
    end
    reset_n = 1'b0;
    mq.delete(); ovf_m = 1'b0;
    #1;
    n_chk++;
    if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00 || afull !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d valid=%b ovf=%b data=%h afull=%b, required all zero",
               count, out_valid, overflow, out_data, afull);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL post_reset_push: valid=%b data=%h count=%0d, required 1 3c 1", out_valid, out_data, count);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_fill_drain_overflow();
    test_full_push_pop();
    test_stream_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the FIFO entry count; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have parameter AFULL_LEVEL, default 12, giving the almost-full threshold; legal range is 1 to DEPTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_data, input, 8 bits: received byte from the UART receiver.
REQ-006 The block SHALL have port in_valid, input, 1 bit: one-cycle pulse qualifying in_data (receiver done strobe).
REQ-007 The block SHALL have port out_data, output, 8 bits: oldest stored byte.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-011 The block SHALL have port afull, output, 1 bit: occupancy at or above AFULL_LEVEL.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a byte was dropped.
REQ-013 The block SHALL have port ovf_clear, input, 1 bit: synchronous clear of overflow.

Function
REQ-014 Push: on a rising edge with in_valid=1 and FIFO not full, in_data SHALL be written at the write pointer, and the write pointer SHALL advance by 1 modulo DEPTH.
REQ-015 Pop: on a rising edge with out_valid=1 and out_ready=1, the read pointer SHALL advance by 1 modulo DEPTH.
REQ-016 Ordering SHALL be first-word-fall-through: out_data equals the entry at the read pointer whenever out_valid=1.
REQ-017 out_data SHALL be 8'h00 whenever out_valid=0.
REQ-018 out_valid SHALL equal (count != 0), and SHALL be registered state, not derived from in_valid.
REQ-019 Latency: a byte pushed into an empty FIFO at edge N SHALL appear with out_valid=1 in the cycle following edge N; there is no same-cycle bypass.
REQ-020 count SHALL update at each edge as follows: +1 on push only; -1 on pop only; unchanged on push plus pop, or on neither.
REQ-021 Full (count=DEPTH) with in_valid=1 and no pop in the same cycle: the byte SHALL be dropped, storage and pointers SHALL be unchanged, and overflow SHALL be set to 1 at that edge.
REQ-022 Full with in_valid=1 and a pop in the same cycle: the push SHALL be accepted, no drop SHALL occur, and count SHALL remain DEPTH.
REQ-023 Empty (count=0): out_ready SHALL be ignored, and the read pointer and count SHALL NOT underflow.
REQ-024 overflow SHALL remain 1 until an edge with ovf_clear=1; if ovf_clear and a new drop coincide, overflow SHALL stay 1 (set wins).
REQ-025 afull SHALL equal (count >= AFULL_LEVEL), decoded combinationally from the count register only.
REQ-026 Pointer wrap SHALL be seamless: continuous traffic across the DEPTH-1 to 0 boundary SHALL preserve order with no lost or duplicated bytes.
REQ-027 Storage contents SHALL NOT require reset; stale data SHALL never be visible because of REQ-017.

Reset
REQ-028 While reset_n=0, asynchronously: read pointer=0, write pointer=0, count=0, out_valid=0, out_data=8'h00, afull=0, overflow=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored bytes. The first edge after reset_n deasserts SHALL behave as normal operation from empty; an in_valid pulse on that edge SHALL be pushed.

Verification
REQ-030 After reset, push 8'hA5 with out_ready=0 -> next cycle: out_valid=1, out_data=8'hA5, count=1, afull=0.
REQ-031 Push 16 bytes 8'h00..8'h0F with out_ready=0 -> count=16; afull first goes to 1 when count=12; then drain with out_ready=1 -> bytes 00..0F in order, and out_valid=0 with out_data=8'h00 afterwards.
REQ-032 FIFO full, push 8'hEE with out_ready=0 -> byte dropped, overflow=1, count=16. Drain -> 8'hEE is never output. Pulse ovf_clear -> overflow=0.
REQ-033 FIFO full, push 8'h77 and pop in the same cycle -> count stays 16, overflow stays 0, and 8'h77 is output last after the drain.
REQ-034 Stream 40 bytes with out_ready toggling every cycle, wrapping the pointers -> output sequence identical to input, with no overflow.
REQ-035 Fill to count=5, assert reset_n=0 for 1 cycle -> count=0, out_valid=0, overflow=0; a subsequent push of 8'h3C appears as the first output.
